alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared `alu_top` instance. It accepts operation requests from two independent requesters and grants one at a time. For the granted request it latches the operands and opcode, pulses the ALU start, and waits for the ALU done flag or a timeout. It then returns the 8-bit result to the granted requester with a one-cycle acknowledge.

## Interface
- `TIMEOUT`, default 32: maximum cycles spent in WAIT before the operation is aborted with an error; legal range 2..255.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request from requester 0/1; held high with stable operands until ack.
- `op0`, `op1`  in  2  opcode from requester 0/1: 00 add, 01 sub, 10 mul, 11 div.
- `a0`, `a1`  in  8  operand A from requester 0/1.
- `b0`, `b1`  in  8  operand B from requester 0/1.
- `ack0`, `ack1`  out  1  one-cycle completion pulse to requester 0/1.
- `res0`, `res1`  out  8  result; valid only while the matching ack is high.
- `err0`, `err1`  out  1  timeout flag; valid only while the matching ack is high.
- `alu_start`  out  1  one-cycle start pulse to the ALU.
- `alu_opcode`  out  2  registered opcode to the ALU.
- `alu_a`, `alu_b`  out  8  registered operands to the ALU; held stable from grant until RESP.
- `alu_result`  in  8  ALU result bus.
- `alu_done`  in  1  ALU done flag.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - If any req is high, choose the winner, latch its opcode and operands into the `alu_*` registers, set `owner`, clear the timeout counter, and go to LAUNCH.
  - Otherwise stay in IDLE.
- **Arbitration:** a `last` pointer holds the previously granted port.
  - Single request: that port wins.
  - Both requesting: the port ≠ `last` wins.
  - `last` is updated to the winner at grant. Reset value is `last`=1, so port 0 wins the first contention.
- **LAUNCH:** `alu_start`=1 for exactly this cycle. `alu_done` is ignored, since it may be stale from the previous op. Go to WAIT.
- **WAIT:** the counter increments every cycle.
  - `alu_done`=1: capture `alu_result` into the result register, set error=0, go to RESP.
  - Otherwise, if counter = TIMEOUT−1: set result=0x00, error=1, go to RESP.
  - If both conditions hold on the same edge, done wins.
- **RESP:** assert the owner's ack, with its res and err driven from the registers. The other port's ack/res/err stay 0. Go to IDLE.
- **Requester handshake:** the requester must drop req by the second rising edge after ack rises. A req still high in IDLE after that is treated as a new request.
- Changing the requester's operands after grant has no effect; the ALU side runs from the latched copies.
- The result is taken from `alu_result` unchanged (8 bits). For mul this is the low byte of the product; for div it is the quotient.
- **Reset** (asynchronous, any state, including mid-WAIT):
  - State → IDLE, `last`→1, counter→0.
  - All outputs → 0: acks, res, errs, `alu_start`, `alu_opcode`, `alu_a`, `alu_b`, `busy`.
  - An in-flight operation is dropped and produces no ack.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from req or `alu_done` to any output.
- Edge E0 samples req in IDLE. `alu_start` is high from E0 to E1. WAIT begins at E1.
- If `alu_done` is sampled high at edge Ek (k≥2), ack is high from Ek to Ek+1 and `busy` drops at Ek+1.
- Minimum request-to-ack latency is 2 edges after grant; overall throughput is 4 cycles per op plus ALU latency.
- Timeout: counter values 0..TIMEOUT−1 are sampled in WAIT, so ack+err is asserted TIMEOUT+1 edges after grant.
- Back-to-back operation: the next grant can occur at the edge immediately after the RESP cycle.

## Test plan
- **Single add:** after reset, req0 with op0=00, a0=5, b0=3; `alu_done` driven high 3 cycles after `alu_start`. Required: one `alu_start` pulse with `alu_a`=5, `alu_b`=3; then ack0 for one cycle with res0=8 (0x08), err0=0; ack1 stays 0.
- **Contention:** req0 and req1 rise on the same edge immediately after reset. Required: port 0 is served first, then port 1 is granted on the edge after RESP. Ack order is ack0 then ack1.
- **Fairness:** both req held continuously for 4 ops. Required: grants alternate 0,1,0,1, and no port is served twice in a row while the other is requesting.
- **Timeout:** TIMEOUT=8, `alu_done` stuck at 0, req1 sub. Required: ack1 with err1=1 and res1=0x00 exactly 9 edges after grant; then IDLE and `busy`=0.
- **Mul pass-through and stale done:** req0 with op=10, a=12, b=10; `alu_done` held high during LAUNCH, then ALU returns 0x78. Required: the LAUNCH-cycle done is ignored, `alu_opcode`=10, res0=0x78.
- **Reset mid-WAIT:** assert reset 2 cycles into WAIT. Required: all outputs read 0 immediately and no ack ever occurs for that op. After release, a fresh req1 is served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the shared ALU.
// Latches the winner's op, pulses alu_start, waits for done or timeout, then acks the owner.
module alu_arbiter #(
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] res0,
  output logic [7:0] res1,
  output logic       err0,
  output logic       err1,
  output logic       alu_start,
  output logic [1:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  input  logic       alu_done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last;
  logic       owner;
  logic [7:0] cnt;
  logic [7:0] res_q;
  logic       err_q;
  logic       win;

  // Contention goes to the port that was not served last.
  assign win = (req0 & req1) ? ~last : req1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      alu_start  <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner      <= win;
            last       <= win;
            cnt        <= '0;
            alu_opcode <= win ? op1 : op0;
            alu_a      <= win ? a1 : a0;
            alu_b      <= win ? b1 : b0;
            alu_start  <= 1'b1;
            state      <= LAUNCH;
          end
        end
        // done may still be asserted from the previous op, so it is not looked at here
        LAUNCH: state <= WAIT;
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (alu_done) begin
            res_q <= alu_result;
            err_q <= 1'b0;
            state <= RESP;
          end else if (cnt == CNT_LAST) begin
            res_q <= '0;
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response outputs are decoded from registered state only.
  always_comb begin
    ack0 = (state == RESP) & ~owner;
    ack1 = (state == RESP) &  owner;
    res0 = ack0 ? res_q : 8'h00;
    res1 = ack1 ? res_q : 8'h00;
    err0 = ack0 & err_q;
    err1 = ack1 & err_q;
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: hand-computed results, latencies and grant order.
module tb_alu_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [7:0] a0, a1, b0, b1;
  logic       ack0, ack1;
  logic [7:0] res0, res1;
  logic       err0, err1;
  logic       alu_start;
  logic [1:0] alu_opcode;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_result;
  logic       alu_done;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_ack0 = 0;
  int n_ack1 = 0;
  int mode = 0;  // 0: done 3 cycles after start, 1: done stuck low, 2: stale done in LAUNCH

  alu_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1), .res0(res0), .res1(res1),
    .err0(err0), .err1(err1),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_done(alu_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ack0) n_ack0++;
    if (ack1) n_ack1++;
  end

  // Simple ALU stand-in driven off the latched operands.
  initial begin
    int c;
    logic [7:0] r;
    c = 0;
    r = 8'h00;
    alu_done = 1'b0;
    alu_result = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (alu_start) begin
        c = 1;
        case (alu_opcode)
          2'd0:    r = alu_a + alu_b;
          2'd1:    r = alu_a - alu_b;
          2'd2:    r = 8'(alu_a * alu_b);
          default: r = (alu_b == 8'd0) ? 8'hff : alu_a / alu_b;
        endcase
      end else if (c > 0) begin
        c++;
      end
      alu_done = 1'b0;
      if (mode == 0 && c == 3) begin alu_done = 1'b1; alu_result = r; end
      if (mode == 2 && c == 1) begin alu_done = 1'b1; alu_result = 8'hee; end
      if (mode == 2 && c == 3) begin alu_done = 1'b1; alu_result = r; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic [1:0] who);
    who = 2'b00;
    for (int i = 0; i < 30 && who == 2'b00; i++) begin
      tick();
      who = {ack1, ack0};
    end
    if (who == 2'b00) chk("ack_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  logic [1:0] who;
  int acks_before;

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 2'd0; op1 = 2'd0;
    a0 = 8'd0; a1 = 8'd0; b0 = 8'd0; b1 = 8'd0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_alu_a", alu_a, 0);
    reset = 1'b1;

    // single add, done 3 cycles after start
    req0 = 1'b1; op0 = 2'd0; a0 = 8'd5; b0 = 8'd3;
    tick();
    chk("add_start", alu_start, 1);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 3);
    chk("add_busy", busy, 1);
    tick();
    chk("add_start_pulse", alu_start, 0);
    tick();
    chk("add_ack_early", ack0, 0);
    tick();
    chk("add_ack0", ack0, 1);
    chk("add_res0", res0, 8'h08);
    chk("add_err0", err0, 0);
    chk("add_ack1", ack1, 0);
    req0 = 1'b0;
    tick();
    chk("add_ack0_pulse", ack0, 0);
    chk("add_busy_done", busy, 0);

    // contention straight after reset
    do_reset();
    req0 = 1'b1; op0 = 2'd0; a0 = 8'd1;  b0 = 8'd2;
    req1 = 1'b1; op1 = 2'd1; a1 = 8'd10; b1 = 8'd3;
    wait_ack(who);
    chk("cont_first", who, 2'b01);
    chk("cont_res0", res0, 8'd3);
    req0 = 1'b0;
    tick();
    chk("cont_idle_busy", busy, 0);
    tick();
    chk("cont_grant1_start", alu_start, 1);
    chk("cont_grant1_a", alu_a, 8'd10);
    chk("cont_grant1_op", alu_opcode, 2'd1);
    wait_ack(who);
    chk("cont_second", who, 2'b10);
    chk("cont_res1", res1, 8'd7);
    req1 = 1'b0;
    tick();

    // fairness: both held for four ops
    req0 = 1'b1; op0 = 2'd2; a0 = 8'd2; b0 = 8'd2;
    req1 = 1'b1; op1 = 2'd0; a1 = 8'd7; b1 = 8'd1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(who);
      chk($sformatf("fair_order%0d", i), who, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("fair_res%0d", i), (i % 2 == 0) ? res0 : res1, (i % 2 == 0) ? 8'd4 : 8'd8);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    // timeout with done stuck low
    mode = 1;
    req1 = 1'b1; op1 = 2'd1; a1 = 8'd9; b1 = 8'd4;
    tick();
    chk("to_start", alu_start, 1);
    chk("to_opcode", alu_opcode, 2'd1);
    repeat (7) tick();
    tick();
    chk("to_ack_early", ack1, 0);
    tick();
    chk("to_ack1", ack1, 1);
    chk("to_err1", err1, 1);
    chk("to_res1", res1, 8'h00);
    chk("to_ack0", ack0, 0);
    req1 = 1'b0;
    tick();
    chk("to_busy_done", busy, 0);
    chk("to_ack1_pulse", ack1, 0);

    // mul with stale done during LAUNCH
    mode = 2;
    req0 = 1'b1; op0 = 2'd2; a0 = 8'd12; b0 = 8'd10;
    tick();
    chk("mul_opcode", alu_opcode, 2'd2);
    tick();
    chk("mul_busy", busy, 1);
    tick();
    chk("mul_stale_ignored", ack0, 0);
    tick();
    chk("mul_ack0", ack0, 1);
    chk("mul_res0", res0, 8'h78);
    chk("mul_err0", err0, 0);
    req0 = 1'b0;
    tick();
    tick();

    // asynchronous reset two cycles into WAIT
    mode = 1;
    req0 = 1'b1; op0 = 2'd3; a0 = 8'h55; b0 = 8'h66;
    repeat (4) tick();
    chk("mid_busy_before", busy, 1);
    acks_before = n_ack0 + n_ack1;
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_start", alu_start, 0);
    chk("mid_opcode", alu_opcode, 0);
    chk("mid_alu_a", alu_a, 0);
    chk("mid_alu_b", alu_b, 0);
    chk("mid_ack0", ack0, 0);
    chk("mid_res0", res0, 0);
    chk("mid_err0", err0, 0);
    req0 = 1'b0;
    tick();
    reset = 1'b1;
    repeat (12) tick();
    chk("mid_no_ack", n_ack0 + n_ack1, acks_before);
    mode = 0;
    req1 = 1'b1; op1 = 2'd0; a1 = 8'd20; b1 = 8'd22;
    wait_ack(who);
    chk("post_rst_port", who, 2'b10);
    chk("post_rst_res1", res1, 8'd42);
    chk("post_rst_err1", err1, 0);
    req1 = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
